// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD digit loader
package bcd_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam int         NUM_DIGITS_C = 4;

  // True when the nibble is a legal decimal digit.
  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_loader_if.sv
// rtl/bcd_digit_loader_if.sv - digit input / word output bundle for the loader
interface bcd_digit_loader_if;
  import bcd_pkg::*;

  logic [3:0]                  digit_in;
  logic                        digit_valid;
  logic                        digit_ready;
  logic                        clear;
  logic                        word_ack;
  logic [4*NUM_DIGITS_C-1:0]   bcd_word;
  logic                        word_valid;
  logic [2:0]                  digit_count;
  logic                        err_digit;
  logic                        timeout_evt;

  // Producer/consumer side.
  modport master (
    output digit_in, digit_valid, clear, word_ack,
    input  digit_ready, bcd_word, word_valid, digit_count, err_digit, timeout_evt
  );

  // Loader side.
  modport slave (
    input  digit_in, digit_valid, clear, word_ack,
    output digit_ready, bcd_word, word_valid, digit_count, err_digit, timeout_evt
  );

endinterface

// File: rtl/bcd_idle_timer.sv
// rtl/bcd_idle_timer.sv - idle cycle counter with single-cycle expiry flag
module bcd_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_expire
);

  // Value the counter holds on the idle cycle that completes the timeout.
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_run;
  logic             w_hit;

  assign w_run    = i_enable && (TIMEOUT_CYCLES != 0) && !i_restart;
  assign w_hit    = (r_cnt == LAST);
  assign o_expire = w_run && w_hit;

  // Count idle cycles; drop to zero on activity, when disabled, or on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_run || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_digit_loader.sv
// rtl/bcd_digit_loader.sv - shifts BCD digits into a 4-digit word and holds it until acknowledged
module bcd_digit_loader
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_digit_loader_if.slave   bus
);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [4*NUM_DIGITS-1:0]   r_word;
  logic [2:0]                r_count;
  logic                      r_err;
  logic                      r_tevt;

  logic                      w_accept;
  logic                      w_digit_ok;
  logic                      w_last_digit;
  logic                      w_ack;
  logic                      w_timer_en;
  logic                      w_expire;

  assign w_accept     = bus.digit_valid && (r_state == COLLECT);
  assign w_digit_ok   = is_bcd(bus.digit_in);
  assign w_last_digit = (r_count == 3'(NUM_DIGITS - 1));
  assign w_ack        = bus.word_ack && (r_state == HOLD);
  // Only a partial word in COLLECT can time out.
  assign w_timer_en   = (r_state == COLLECT) && (r_count != 3'd0);

  bcd_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_idle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_accept || bus.clear),
    .i_enable  (w_timer_en),
    .o_expire  (w_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: clear aborts, ack releases HOLD, the final valid digit enters HOLD.
  always_comb begin
    w_next_state = r_state;
    if (bus.clear) begin
      w_next_state = COLLECT;
    end else begin
      case (r_state)
        COLLECT: begin
          if (!w_expire && w_accept && w_digit_ok && w_last_digit) begin
            w_next_state = HOLD;
          end
        end
        HOLD: begin
          if (w_ack) begin
            w_next_state = COLLECT;
          end
        end
        default: w_next_state = COLLECT;
      endcase
    end
  end

  // Word, count and pulse registers in priority clear > ack > timeout > accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_tevt  <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_tevt <= 1'b0;
      if (bus.clear || w_ack) begin
        r_word  <= '0;
        r_count <= '0;
      end else if (w_expire) begin
        r_word  <= '0;
        r_count <= '0;
        r_tevt  <= 1'b1;
      end else if (w_accept) begin
        if (w_digit_ok) begin
          r_word  <= {r_word[4*NUM_DIGITS-5:0], bus.digit_in};
          r_count <= r_count + 3'd1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.digit_ready = (r_state == COLLECT);
  assign bus.word_valid  = (r_state == HOLD);
  assign bus.bcd_word    = r_word;
  assign bus.digit_count = r_count;
  assign bus.err_digit   = r_err;
  assign bus.timeout_evt = r_tevt;

endmodule

// File: tb/tb_bcd_digit_loader.sv
// tb/tb_bcd_digit_loader.sv - scoreboard bench for bcd_digit_loader
module tb_bcd_digit_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bcd_digit_loader_if bus ();

  bcd_digit_loader #(
    .NUM_DIGITS     (4),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_word = '0;
  int          model_count = 0;

  // Present one digit for one clock and update the reference model.
  task automatic send_digit(input logic [3:0] d);
    bus.digit_in    = d;
    bus.digit_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.digit_valid = 1'b0;
    if (bcd_pkg::is_bcd(d)) begin
      model_word  = {model_word[11:0], d};
      model_count = model_count + 1;
      if (model_count == 4) exp_q.push_back(model_word);
    end
  endtask

  task automatic model_clear();
    model_word  = '0;
    model_count = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.digit_in = '0; bus.digit_valid = 0; bus.clear = 0; bus.word_ack = 0;
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.bcd_word !== 16'h0) begin n_errors++; $display("FAIL reset_word got %h exp 0000", bus.bcd_word); end
    n_checks++; if (bus.digit_count !== 3'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", bus.digit_count); end
    n_checks++; if (bus.word_valid !== 1'b0 || bus.err_digit !== 1'b0 || bus.timeout_evt !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags got wv=%b err=%b to=%b exp 0 0 0", bus.word_valid, bus.err_digit, bus.timeout_evt); end
    n_checks++; if (bus.digit_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b exp 1", bus.digit_ready); end
  endtask

  task automatic test_basic_load();
    logic [15:0] e;
    send_digit(4'd1); send_digit(4'd2); send_digit(4'd3);
    n_checks++; if (bus.word_valid !== 1'b0 || bus.digit_count !== 3'd3) begin
      n_errors++; $display("FAIL basic_partial got wv=%b cnt=%0d exp 0 3", bus.word_valid, bus.digit_count); end
    send_digit(4'd6);
    n_checks++; if (bus.word_valid !== 1'b1 || bus.digit_ready !== 1'b0) begin
      n_errors++; $display("FAIL basic_hold got wv=%b rdy=%b exp 1 0", bus.word_valid, bus.digit_ready); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    n_checks++; if (bus.bcd_word !== e || e !== 16'h1236) begin
      n_errors++; $display("FAIL basic_word got %h exp %h", bus.bcd_word, e); end
    bus.word_ack = 1'b1; tick(); bus.word_ack = 1'b0; model_clear();
    n_checks++; if (bus.word_valid !== 1'b0 || bus.digit_count !== 3'd0 || bus.bcd_word !== 16'h0) begin
      n_errors++; $display("FAIL basic_ack got wv=%b cnt=%0d word=%h exp 0 0 0000", bus.word_valid, bus.digit_count, bus.bcd_word); end
  endtask

  task automatic test_invalid_digit();
    logic [15:0] e;
    send_digit(4'd4);
    send_digit(4'hB);
    n_checks++; if (bus.err_digit !== 1'b1 || bus.digit_count !== 3'd1 || bus.bcd_word !== 16'h0004) begin
      n_errors++; $display("FAIL invalid_pulse got err=%b cnt=%0d word=%h exp 1 1 0004", bus.err_digit, bus.digit_count, bus.bcd_word); end
    send_digit(4'd5);
    n_checks++; if (bus.err_digit !== 1'b0) begin n_errors++; $display("FAIL invalid_pulse_len got %b exp 0", bus.err_digit); end
    send_digit(4'd7); send_digit(4'd8);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    n_checks++; if (bus.word_valid !== 1'b1 || bus.bcd_word !== e || e !== 16'h4578) begin
      n_errors++; $display("FAIL invalid_word got wv=%b word=%h exp 1 %h", bus.word_valid, bus.bcd_word, e); end
    bus.word_ack = 1'b1; tick(); bus.word_ack = 1'b0; model_clear();
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int bad = 0;
    for (int i = 0; i < 4; i++) send_digit(4'd9);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    n_checks++; if (bus.word_valid !== 1'b1 || bus.bcd_word !== e) begin
      n_errors++; $display("FAIL bp_word got wv=%b word=%h exp 1 %h", bus.word_valid, bus.bcd_word, e); end
    bus.digit_in = 4'd3; bus.digit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.bcd_word !== 16'h9999 || bus.digit_ready !== 1'b0 || bus.digit_count !== 3'd4) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL bp_frozen got %0d bad cycles exp 0", bad); end
    bus.word_ack = 1'b1; tick(); bus.word_ack = 1'b0; model_clear();
    n_checks++; if (bus.digit_count !== 3'd0 || bus.word_valid !== 1'b0) begin
      n_errors++; $display("FAIL bp_release got cnt=%0d wv=%b exp 0 0", bus.digit_count, bus.word_valid); end
    tick(); bus.digit_valid = 1'b0;
    model_word = 16'h0003; model_count = 1;
    n_checks++; if (bus.digit_count !== 3'd1 || bus.bcd_word !== model_word) begin
      n_errors++; $display("FAIL bp_first got cnt=%0d word=%h exp 1 %h", bus.digit_count, bus.bcd_word, model_word); end
    bus.clear = 1'b1; tick(); bus.clear = 1'b0; model_clear();
  endtask

  task automatic test_timeout();
    int early = 0;
    int spur = 0;
    send_digit(4'd2); send_digit(4'd5);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.timeout_evt !== 1'b0 || bus.digit_count !== 3'd2) early++;
    end
    n_checks++; if (early != 0) begin n_errors++; $display("FAIL timeout_early got %0d bad cycles exp 0", early); end
    tick(); model_clear();
    n_checks++; if (bus.timeout_evt !== 1'b1 || bus.digit_count !== 3'd0 || bus.bcd_word !== 16'h0) begin
      n_errors++; $display("FAIL timeout_fire got to=%b cnt=%0d word=%h exp 1 0 0000", bus.timeout_evt, bus.digit_count, bus.bcd_word); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.timeout_evt !== 1'b0) spur++;
    end
    n_checks++; if (spur != 0) begin n_errors++; $display("FAIL timeout_idle got %0d pulses exp 0", spur); end
  endtask

  task automatic test_clear();
    logic [15:0] e;
    send_digit(4'd1); send_digit(4'd2); send_digit(4'd3);
    bus.digit_in = 4'd7; bus.digit_valid = 1'b1; bus.clear = 1'b1;
    tick();
    bus.digit_valid = 1'b0; bus.clear = 1'b0; model_clear();
    n_checks++; if (bus.digit_count !== 3'd0 || bus.bcd_word !== 16'h0 || bus.word_valid !== 1'b0) begin
      n_errors++; $display("FAIL clear_accept got cnt=%0d word=%h wv=%b exp 0 0000 0", bus.digit_count, bus.bcd_word, bus.word_valid); end
    send_digit(4'd8); send_digit(4'd0); send_digit(4'd4); send_digit(4'd2);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    n_checks++; if (bus.word_valid !== 1'b1 || bus.bcd_word !== e || e !== 16'h8042) begin
      n_errors++; $display("FAIL clear_fill got wv=%b word=%h exp 1 %h", bus.word_valid, bus.bcd_word, e); end
    bus.clear = 1'b1; tick(); bus.clear = 1'b0; model_clear();
    n_checks++; if (bus.word_valid !== 1'b0 || bus.digit_count !== 3'd0 || bus.digit_ready !== 1'b1) begin
      n_errors++; $display("FAIL clear_hold got wv=%b cnt=%0d rdy=%b exp 0 0 1", bus.word_valid, bus.digit_count, bus.digit_ready); end
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    send_digit(4'd5); send_digit(4'd6);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    n_checks++; if (bus.bcd_word !== 16'h0 || bus.digit_count !== 3'd0 || bus.word_valid !== 1'b0) begin
      n_errors++; $display("FAIL async_reset got word=%h cnt=%0d wv=%b exp 0000 0 0", bus.bcd_word, bus.digit_count, bus.word_valid); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.digit_ready !== 1'b1) begin n_errors++; $display("FAIL async_ready got %b exp 1", bus.digit_ready); end
    send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'd4);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    n_checks++; if (bus.word_valid !== 1'b1 || bus.bcd_word !== e || e !== 16'h1234) begin
      n_errors++; $display("FAIL async_reload got wv=%b word=%h exp 1 %h", bus.word_valid, bus.bcd_word, e); end
    bus.word_ack = 1'b1; tick(); bus.word_ack = 1'b0; model_clear();
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_invalid_digit();
    test_back_to_back();
    test_timeout();
    test_clear();
    test_async_reset();
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
